// File: rtl/ram_dp_sync_param.sv
// Parametrised synchronous dual-port RAM: port A write + registered read-back,
// port B registered read with valid flag, plus a clear sequencer that runs after
// reset or on clr_req. Optional per-word even parity under RAM_DP_PARITY_EN.
module ram_dp_sync_param #(
    parameter int                 DATA_W        = 4,
    parameter int                 ADDR_W        = 5,
    parameter int                 WRITE_MODE    = 0,
    parameter int                 COLLISION_FWD = 1,
    parameter logic [DATA_W-1:0]  INIT_VAL      = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] di,
    output logic [DATA_W-1:0] spo,
    input  logic              dpre,
    input  logic [ADDR_W-1:0] dpra,
    output logic [DATA_W-1:0] dpo,
    output logic              dpo_valid,
    input  logic              clr_req,
    output logic              init_busy
`ifdef RAM_DP_PARITY_EN
    ,
    input  logic              par_flip,
    output logic              perr_b
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_DP_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              busy;

    logic [MEM_W-1:0]  mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [MEM_W-1:0]  mem_wd;
    logic [MEM_W-1:0]  user_word;
    logic [MEM_W-1:0]  init_word;
    logic [MEM_W-1:0]  b_word;
    logic              collide;

    // Stored words carry their parity bit above the data when parity is enabled.
`ifdef RAM_DP_PARITY_EN
    assign user_word = {(^di) ^ par_flip, di};
    assign init_word = {^INIT_VAL, INIT_VAL};
`else
    assign user_word = di;
    assign init_word = INIT_VAL;
`endif

    assign busy      = (state_q == ST_CLEAR);
    assign init_busy = busy;

    // Reset lands in CLEAR so the array is swept before first use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            ST_CLEAR: begin
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // The sequencer owns the write port while clearing; user writes are dropped.
    always_comb begin
        mem_we = busy | we;
        mem_wa = busy ? clr_ptr_q : a;
        mem_wd = busy ? init_word : user_word;
    end

    // NOTE: the array has no reset; the clear sequencer initialises it instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign collide = we && (a == dpra);
    assign b_word  = ((COLLISION_FWD != 0) && collide) ? user_word : mem[dpra];

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spo       <= '0;
            dpo       <= '0;
            dpo_valid <= 1'b0;
        end else if (busy) begin
            dpo_valid <= 1'b0;
        end else begin
            if ((WRITE_MODE != 0) && we) begin
                spo <= di;
            end else begin
                spo <= mem[a][DATA_W-1:0];
            end
            dpo_valid <= dpre;
            if (dpre) begin
                dpo <= b_word[DATA_W-1:0];
            end
        end
    end

`ifdef RAM_DP_PARITY_EN
    // A correctly stored word has even overall parity; odd means corruption.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_b <= 1'b0;
        end else if (busy) begin
            perr_b <= 1'b0;
        end else begin
            perr_b <= dpre && (^b_word);
        end
    end
`endif

endmodule

// File: tb/tb_ram_dp_sync_param.sv
// Self-checking bench for ram_dp_sync_param: two instances (read-first/forwarding
// and write-first/no-forwarding with INIT_VAL=0101) checked against an array model.
module tb_ram_dp_sync_param;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we = 1'b0;
    logic [4:0] a = '0;
    logic [3:0] di = '0;
    logic       dpre = 1'b0;
    logic [4:0] dpra = '0;
    logic       clr_req = 1'b0;
    logic       par_flip = 1'b0;

    logic [3:0] spo0, dpo0, spo1, dpo1;
    logic       v0, v1, busy0, busy1;
`ifdef RAM_DP_PARITY_EN
    logic       perr0, perr1;
`endif

    always #5 clk = ~clk;

    ram_dp_sync_param #(.DATA_W(4), .ADDR_W(5), .WRITE_MODE(0), .COLLISION_FWD(1),
                        .INIT_VAL(4'b0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .we(we), .a(a), .di(di), .spo(spo0),
        .dpre(dpre), .dpra(dpra), .dpo(dpo0), .dpo_valid(v0),
        .clr_req(clr_req), .init_busy(busy0)
`ifdef RAM_DP_PARITY_EN
        , .par_flip(par_flip), .perr_b(perr0)
`endif
    );

    ram_dp_sync_param #(.DATA_W(4), .ADDR_W(5), .WRITE_MODE(1), .COLLISION_FWD(0),
                        .INIT_VAL(4'b0101)) dut1 (
        .clk(clk), .rst_n(rst_n), .we(we), .a(a), .di(di), .spo(spo1),
        .dpre(dpre), .dpra(dpra), .dpo(dpo1), .dpo_valid(v1),
        .clr_req(clr_req), .init_busy(busy1)
`ifdef RAM_DP_PARITY_EN
        , .par_flip(par_flip), .perr_b(perr1)
`endif
    );

    // Reference model: plain word arrays plus a count of clear cycles remaining.
    logic [3:0] mm  [2][DEPTH];
    logic       pfl [2][DEPTH];
    logic [3:0] e_spo [2];
    logic [3:0] e_dpo [2];
    logic       e_v [2];
    logic       e_perr [2];
    int         clr_left;
    int         errors = 0;
    int         checks = 0;

    function automatic logic [3:0] initv(input int d);
        return (d == 1) ? 4'b0101 : 4'b0000;
    endfunction
    function automatic logic wfirst(input int d);
        return d == 1;
    endfunction
    function automatic logic fwd_on(input int d);
        return d == 0;
    endfunction

    function automatic logic [3:0] g_spo(input int d);
        return (d == 1) ? spo1 : spo0;
    endfunction
    function automatic logic [3:0] g_dpo(input int d);
        return (d == 1) ? dpo1 : dpo0;
    endfunction
    function automatic logic g_v(input int d);
        return (d == 1) ? v1 : v0;
    endfunction
    function automatic logic g_busy(input int d);
        return (d == 1) ? busy1 : busy0;
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic compare();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d spo", d), g_spo(d), e_spo[d]);
            check($sformatf("dut%0d dpo", d), g_dpo(d), e_dpo[d]);
            check($sformatf("dut%0d dpo_valid", d), 4'(g_v(d)), 4'(e_v[d]));
            check($sformatf("dut%0d init_busy", d), 4'(g_busy(d)), 4'(clr_left > 0));
`ifdef RAM_DP_PARITY_EN
            check($sformatf("dut%0d perr_b", d), 4'((d == 1) ? perr1 : perr0), 4'(e_perr[d]));
`endif
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            e_spo[d]  = '0;
            e_dpo[d]  = '0;
            e_v[d]    = 1'b0;
            e_perr[d] = 1'b0;
        end
        clr_left = DEPTH;
    endtask

    // One clock cycle: drive at negedge, predict, check 1 time unit after the edge.
    task automatic step(input logic w, input logic [4:0] aa, input logic [3:0] d,
                        input logic rd, input logic [4:0] ra, input logic cr, input logic pf);
        int  k;
        logic fwd;
        @(negedge clk);
        we = w; a = aa; di = d; dpre = rd; dpra = ra; clr_req = cr; par_flip = pf;
        if (clr_left > 0) begin
            k = DEPTH - clr_left;
            for (int x = 0; x < 2; x++) begin
                mm[x][k]  = initv(x);
                pfl[x][k] = 1'b0;
                e_v[x]    = 1'b0;
                e_perr[x] = 1'b0;
            end
            clr_left--;
        end else begin
            for (int x = 0; x < 2; x++) begin
                e_spo[x] = (wfirst(x) && w) ? d : mm[x][aa];
                e_v[x]   = rd;
                if (rd) begin
                    fwd       = fwd_on(x) && w && (aa == ra);
                    e_dpo[x]  = fwd ? d : mm[x][ra];
                    e_perr[x] = fwd ? pf : pfl[x][ra];
                end else begin
                    e_perr[x] = 1'b0;
                end
                if (w) begin
                    mm[x][aa]  = d;
                    pfl[x][aa] = pf;
                end
            end
            if (cr) clr_left = DEPTH;
        end
        @(posedge clk);
        #1;
        compare();
    endtask

    // Runs a clear with random (to-be-ignored) traffic, optionally targeting a=2.
    task automatic run_clear(input logic hit_a2);
        int n;
        n = 0;
        while (busy0 === 1'b1 && n < 100) begin
            step(hit_a2 ? 1'b1 : 1'($urandom), hit_a2 ? 5'd2 : 5'($urandom), 4'($urandom),
                 1'($urandom), 5'($urandom), 1'($urandom), 1'b0);
            n++;
        end
        check("clear length", 4'(n == DEPTH), 4'b0001);
    endtask

    task automatic reset_outputs_zero(input string tag);
        check({tag, " dut0 spo"}, spo0, 4'b0000);
        check({tag, " dut0 dpo"}, dpo0, 4'b0000);
        check({tag, " dut0 valid"}, 4'(v0), 4'b0000);
        check({tag, " dut1 spo"}, spo1, 4'b0000);
        check({tag, " dut1 dpo"}, dpo1, 4'b0000);
        check({tag, " dut1 valid"}, 4'(v1), 4'b0000);
    endtask

    initial begin
        logic       w, cr, pf;
        logic [4:0] aa, ra;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) begin
                mm[d][i]  = '0;
                pfl[d][i] = 1'b0;
            end
        model_reset();

        // Reset and the first sweep.
        repeat (2) @(negedge clk);
        reset_outputs_zero("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_clear(1'b0);

        // Reads of freshly cleared words.
        step(0, 5'd0, 4'd0, 1, 5'd0, 0, 0);
        step(0, 5'd0, 4'd0, 1, 5'd17, 0, 0);
        check("rd17 dut0", dpo0, 4'b0000);
        check("rd17 dut1", dpo1, 4'b0101);
        step(0, 5'd0, 4'd0, 1, 5'd31, 0, 0);
        check("rd31 valid", 4'(v0), 4'b0001);

        // Writes then port B reads.
        step(1, 5'd3,  4'b1010, 0, 5'd0, 0, 0);
        step(1, 5'd10, 4'b1100, 0, 5'd0, 0, 0);
        step(1, 5'd15, 4'b1111, 0, 5'd0, 0, 0);
        step(0, 5'd0, 4'd0, 1, 5'd3, 0, 0);
        check("rd3", dpo0, 4'b1010);
        step(0, 5'd0, 4'd0, 1, 5'd10, 0, 0);
        step(0, 5'd0, 4'd0, 1, 5'd15, 0, 0);
        check("rd15", dpo1, 4'b1111);
        step(0, 5'd0, 4'd0, 1, 5'd7, 0, 0);
        step(0, 5'd0, 4'd0, 0, 5'd7, 0, 0);

        // Read-during-write on port A.
        step(1, 5'd5, 4'b0011, 0, 5'd0, 0, 0);
        step(1, 5'd5, 4'b0110, 0, 5'd0, 0, 0);
        check("rdw read-first", spo0, 4'b0011);
        check("rdw write-first", spo1, 4'b0110);

        // Port B collision.
        step(1, 5'd9, 4'b0001, 0, 5'd0, 0, 0);
        step(1, 5'd9, 4'b1001, 1, 5'd9, 0, 0);
        check("collision fwd", dpo0, 4'b1001);
        check("collision old", dpo1, 4'b0001);
        step(0, 5'd0, 4'd0, 1, 5'd9, 0, 0);
        check("post-collision dut0", dpo0, 4'b1001);
        check("post-collision dut1", dpo1, 4'b1001);

        // Clear request coinciding with a write, user writes to a=2 during the sweep.
        step(1, 5'd2, 4'b1110, 0, 5'd0, 1, 0);
        run_clear(1'b1);
        step(0, 5'd0, 4'd0, 1, 5'd3, 0, 0);
        check("post-clear rd3", dpo1, 4'b0101);
        step(0, 5'd0, 4'd0, 1, 5'd2, 0, 0);
        check("post-clear rd2 dut1", dpo1, 4'b0101);
        check("post-clear rd2 dut0", dpo0, 4'b0000);

        // Reset mid-clear.
        step(1, 5'd3, 4'b1011, 0, 5'd0, 0, 0);
        step(0, 5'd3, 4'd0, 1, 5'd3, 0, 0);
        step(0, 5'd3, 4'd0, 0, 5'd0, 1, 0);
        for (int i = 0; i < 12; i++) step(0, 5'd0, 4'd0, 1, 5'd1, 0, 0);
        #1 rst_n = 1'b0;
        #1 reset_outputs_zero("mid-clear reset");
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_clear(1'b0);

`ifdef RAM_DP_PARITY_EN
        step(1, 5'd4, 4'b0111, 0, 5'd0, 0, 1);
        step(0, 5'd0, 4'd0, 1, 5'd4, 0, 0);
        check("parity error", 4'(perr0 & v0), 4'b0001);
`endif

        // Randomised traffic with occasional clears and forced collisions.
        repeat (400) begin
            w  = 1'($urandom);
            aa = 5'($urandom);
            ra = ($urandom_range(3, 0) == 0) ? aa : 5'($urandom);
            cr = ($urandom_range(59, 0) == 0);
`ifdef RAM_DP_PARITY_EN
            pf = ($urandom_range(7, 0) == 0);
`else
            pf = 1'b0;
`endif
            step(w, aa, 4'($urandom), 1'($urandom), ra, cr, pf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
